// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the FIFO write-side control blocks: FSM encodings and index helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_ctrl_pkg;

    // Arbiter FSM state encodings.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // Width of an index into an n-entry vector, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N.
// Latency: zero (purely combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Scan offsets 1..N from the last winner; the first set request wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter steering one of NUM_CH channels onto a single FIFO write port.
// Latency: grant registered one cycle after request; data path channel->FIFO is zero-latency.
// Backpressure: fifo_full drops ch_ready and fifo_wr_en; beats only count when written.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic                           arb_en,
    input  logic [NUM_CH-1:0]              ch_req,
    input  logic [NUM_CH*LEN_WIDTH-1:0]    ch_len,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]              ch_valid,
    output logic [NUM_CH-1:0]              ch_ready,
    output logic [NUM_CH-1:0]              ch_grant,
    output logic [NUM_CH-1:0]              ch_done,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic [DATA_WIDTH-1:0]          fifo_wr_data,
    output logic                           busy
);

    localparam int IW = idx_width(NUM_CH);
    localparam int CW = LEN_WIDTH + 1;

    arb_state_t           state;
    logic [NUM_CH-1:0]    grant_q;
    logic [NUM_CH-1:0]    done_q;
    logic [IW-1:0]        gidx;
    logic [IW-1:0]        last_grant;
    logic [CW-1:0]        beat_cnt;

    logic [NUM_CH-1:0]    pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;

    logic [LEN_WIDTH-1:0] win_len;
    logic [CW-1:0]        beat_load;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                 sel_valid;
    logic                 in_burst;

    rr_pick #(
        .N  (NUM_CH),
        .IW (IW)
    ) u_rr_pick (
        .req   (ch_req),
        .last  (last_grant),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Length field of the channel that would win this cycle.
    always_comb begin
        win_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick_idx == IW'(i)) begin
                win_len = ch_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // A zero length field encodes the maximum burst of 2^LEN_WIDTH beats.
    assign beat_load = (win_len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, win_len};

    // Data and valid of the channel currently holding the grant.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gidx == IW'(i)) begin
                sel_data  = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = ch_valid[i];
            end
        end
    end

    assign in_burst     = (state == BURST);
    assign fifo_wr_en   = in_burst && sel_valid && !fifo_full;
    assign fifo_wr_data = sel_data;
    assign ch_ready     = (in_burst && !fifo_full) ? grant_q : '0;
    assign ch_grant     = grant_q;
    assign ch_done      = done_q;
    assign busy         = (state != IDLE);

    // Arbiter FSM: grant in IDLE, count written beats in BURST, pulse done in DONE.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            gidx       <= '0;
            beat_cnt   <= '0;
            last_grant <= IW'(NUM_CH - 1);
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (arb_en && pick_any) begin
                        grant_q    <= pick_grant;
                        gidx       <= pick_idx;
                        last_grant <= pick_idx;
                        beat_cnt   <= beat_load;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (fifo_wr_en) begin
                        beat_cnt <= beat_cnt - CW'(1);
                        if (beat_cnt == CW'(1)) begin
                            done_q <= grant_q;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    grant_q <= '0;
                    state   <= IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
